// File: rtl/tpc_refill_ctrl.sv
// Refill sequencer for the MMU translation-path cache register file.
// Picks a victim entry, writes side 0, side 1 and the partial bit, and owns the flush line.
module tpc_refill_ctrl #(
  parameter int N_ENTRIES    = 4,
  parameter int VPN_PART_LEN = 9,
  parameter int PPN_LEN      = 44
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [VPN_PART_LEN-1:0] req_tag0_i,
  input  logic [VPN_PART_LEN-1:0] req_tag1_i,
  input  logic [PPN_LEN-1:0]      req_ppn0_i,
  input  logic [PPN_LEN-1:0]      req_ppn1_i,
  input  logic                    req_partial_i,
  input  logic                    flush_i,
  output logic                    done_o,
  output logic                    abort_o,
  input  logic [N_ENTRIES-1:0]    valid_vec_i,
  output logic                    rf_wr_en_o,
  output logic                    rf_wr_part_en_o,
  output logic [VPN_PART_LEN-1:0] rf_tag_o,
  output logic [PPN_LEN-1:0]      rf_data_o,
  output logic                    rf_partial_o,
  output logic                    rf_flush_o,
  output logic [N_ENTRIES-1:0]    rf_waddr_o,
  output logic                    rf_which_side_o
);

  localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR0  = 3'd1;
  localparam logic [2:0] ST_WR1  = 3'd2;
  localparam logic [2:0] ST_WRP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Lowest-index invalid entry as a one-hot; all zeros when the cache is full.
  function automatic logic [N_ENTRIES-1:0] first_free(input logic [N_ENTRIES-1:0] vv);
    logic [N_ENTRIES-1:0] oh;
    oh = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!vv[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end else begin
        oh = oh;
      end
    end
    return oh;
  endfunction

  logic [2:0]              state_r, state_nxt_s;
  logic [IDX_W-1:0]        rr_ptr_r;
  logic                    use_rr_r;
  logic                    abort_r;
  logic [N_ENTRIES-1:0]    victim_r;
  logic [VPN_PART_LEN-1:0] tag0_r, tag1_r;
  logic [PPN_LEN-1:0]      ppn0_r, ppn1_r;
  logic                    partial_r;

  logic                    ready_s, accept_s;
  logic [N_ENTRIES-1:0]    free_oh_s;
  logic                    full_s;
  logic                    wr_en_s, wr_part_en_s, side_s, partial_s;
  logic [VPN_PART_LEN-1:0] tag_s;
  logic [PPN_LEN-1:0]      data_s;
  logic [N_ENTRIES-1:0]    waddr_s;

  assign ready_s   = (state_r == ST_IDLE) & ~flush_i;
  assign accept_s  = req_valid_i & ready_s;
  assign free_oh_s = first_free(valid_vec_i);
  assign full_s    = &valid_vec_i;

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = accept_s ? ST_WR0 : ST_IDLE;
        ST_WR0:  state_nxt_s = partial_r ? ST_WRP : ST_WR1;
        ST_WR1:  state_nxt_s = ST_WRP;
        ST_WRP:  state_nxt_s = ST_DONE;
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Regfile port decode; write enables are killed in a flush cycle.
  always_comb begin
    wr_en_s      = 1'b0;
    wr_part_en_s = 1'b0;
    side_s       = 1'b0;
    partial_s    = 1'b0;
    tag_s        = '0;
    data_s       = '0;
    waddr_s      = '0;
    case (state_r)
      ST_WR0: begin
        wr_en_s = ~flush_i;
        tag_s   = tag0_r;
        data_s  = ppn0_r;
        waddr_s = victim_r;
      end
      ST_WR1: begin
        wr_en_s = ~flush_i;
        side_s  = 1'b1;
        tag_s   = tag1_r;
        data_s  = ppn1_r;
        waddr_s = victim_r;
      end
      ST_WRP: begin
        wr_part_en_s = ~flush_i;
        partial_s    = partial_r;
        waddr_s      = victim_r;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // State, request latch, victim and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      use_rr_r  <= 1'b0;
      abort_r   <= 1'b0;
      victim_r  <= '0;
      tag0_r    <= '0;
      tag1_r    <= '0;
      ppn0_r    <= '0;
      ppn1_r    <= '0;
      partial_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      abort_r <= flush_i & (state_r != ST_IDLE);
      if (flush_i) begin
        rr_ptr_r <= '0;
      end else if ((state_r == ST_DONE) && use_rr_r) begin
        rr_ptr_r <= (rr_ptr_r == IDX_W'(N_ENTRIES - 1)) ? '0 : rr_ptr_r + IDX_W'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (accept_s) begin
        tag0_r    <= req_tag0_i;
        tag1_r    <= req_tag1_i;
        ppn0_r    <= req_ppn0_i;
        ppn1_r    <= req_ppn1_i;
        partial_r <= req_partial_i;
        use_rr_r  <= full_s;
        victim_r  <= full_s ? (N_ENTRIES'(1) << rr_ptr_r) : free_oh_s;
      end else begin
        use_rr_r <= use_rr_r;
      end
    end
  end

  // Handshake and pass-through lines are held low while reset is asserted.
  assign req_ready_o     = ready_s & ~rst_i;
  assign rf_flush_o      = flush_i & ~rst_i;
  assign done_o          = (state_r == ST_DONE) & ~flush_i;
  assign abort_o         = abort_r;
  assign rf_wr_en_o      = wr_en_s;
  assign rf_wr_part_en_o = wr_part_en_s;
  assign rf_tag_o        = tag_s;
  assign rf_data_o       = data_s;
  assign rf_partial_o    = partial_s;
  assign rf_waddr_o      = waddr_s;
  assign rf_which_side_o = side_s;

endmodule

// File: tb/tb_tpc_refill_ctrl.sv
// Randomized self-checking bench for tpc_refill_ctrl against a transaction-level model.
module tb_tpc_refill_ctrl;
  localparam int N  = 4;
  localparam int VL = 9;
  localparam int PL = 44;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_partial_i, flush_i;
  logic [VL-1:0] req_tag0_i, req_tag1_i, rf_tag_o;
  logic [PL-1:0] req_ppn0_i, req_ppn1_i, rf_data_o;
  logic          done_o, abort_o, rf_wr_en_o, rf_wr_part_en_o, rf_partial_o, rf_flush_o;
  logic          rf_which_side_o;
  logic [N-1:0]  valid_vec_i, rf_waddr_o;

  int checks = 0;
  int errors = 0;
  int m_rr   = 0;

  tpc_refill_ctrl #(.N_ENTRIES(N), .VPN_PART_LEN(VL), .PPN_LEN(PL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_tag0_i(req_tag0_i), .req_tag1_i(req_tag1_i), .req_ppn0_i(req_ppn0_i),
    .req_ppn1_i(req_ppn1_i), .req_partial_i(req_partial_i), .flush_i(flush_i),
    .done_o(done_o), .abort_o(abort_o), .valid_vec_i(valid_vec_i), .rf_wr_en_o(rf_wr_en_o),
    .rf_wr_part_en_o(rf_wr_part_en_o), .rf_tag_o(rf_tag_o), .rf_data_o(rf_data_o),
    .rf_partial_o(rf_partial_o), .rf_flush_o(rf_flush_o), .rf_waddr_o(rf_waddr_o),
    .rf_which_side_o(rf_which_side_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scramble_req();
    req_tag0_i    = VL'($urandom);
    req_tag1_i    = VL'($urandom);
    req_ppn0_i    = {12'($urandom), 32'($urandom)};
    req_ppn1_i    = {12'($urandom), 32'($urandom)};
    req_partial_i = 1'($urandom);
    valid_vec_i   = N'($urandom);
  endtask

  // One full refill; expected victim from the lowest clear bit (~v & (v+1)) or the RR index.
  task automatic do_refill(input logic [VL-1:0] t0, input logic [VL-1:0] t1,
                           input logic [PL-1:0] p0, input logic [PL-1:0] p1,
                           input logic part, input logic [N-1:0] vv);
    logic [N-1:0] vp1, free, exp_oh;
    logic         uses_rr;
    vp1  = vv + N'(1);
    free = ~vv & vp1;
    if (free == '0) begin
      exp_oh  = N'(1) << m_rr;
      uses_rr = 1'b1;
    end else begin
      exp_oh  = free;
      uses_rr = 1'b0;
    end
    req_valid_i = 1'b1; req_tag0_i = t0; req_tag1_i = t1;
    req_ppn0_i = p0; req_ppn1_i = p1; req_partial_i = part; valid_vec_i = vv;
    #1;
    chk("ready_idle", {63'd0, req_ready_o}, 64'd1);
    tick();
    req_valid_i = 1'b0;
    scramble_req();
    #1;
    chk("wr0_en", {63'd0, rf_wr_en_o}, 64'd1);
    chk("wr0_side", {63'd0, rf_which_side_o}, 64'd0);
    chk("wr0_tag", 64'(rf_tag_o), 64'(t0));
    chk("wr0_data", 64'(rf_data_o), 64'(p0));
    chk("wr0_waddr", 64'(rf_waddr_o), 64'(exp_oh));
    chk("wr0_part_en", {63'd0, rf_wr_part_en_o}, 64'd0);
    chk("wr0_ready", {63'd0, req_ready_o}, 64'd0);
    if (!part) begin
      tick(); #1;
      chk("wr1_en", {63'd0, rf_wr_en_o}, 64'd1);
      chk("wr1_side", {63'd0, rf_which_side_o}, 64'd1);
      chk("wr1_tag", 64'(rf_tag_o), 64'(t1));
      chk("wr1_data", 64'(rf_data_o), 64'(p1));
      chk("wr1_waddr", 64'(rf_waddr_o), 64'(exp_oh));
    end
    tick(); #1;
    chk("wrp_part_en", {63'd0, rf_wr_part_en_o}, 64'd1);
    chk("wrp_en", {63'd0, rf_wr_en_o}, 64'd0);
    chk("wrp_partial", {63'd0, rf_partial_o}, {63'd0, part});
    chk("wrp_waddr", 64'(rf_waddr_o), 64'(exp_oh));
    chk("wrp_done", {63'd0, done_o}, 64'd0);
    tick(); #1;
    chk("done_pulse", {63'd0, done_o}, 64'd1);
    chk("done_wr_en", {63'd0, rf_wr_en_o}, 64'd0);
    chk("done_waddr", 64'(rf_waddr_o), 64'd0);
    chk("done_ready", {63'd0, req_ready_o}, 64'd0);
    if (uses_rr) m_rr = (m_rr + 1) % N;
    tick(); #1;
    chk("idle_done", {63'd0, done_o}, 64'd0);
    chk("idle_ready", {63'd0, req_ready_o}, 64'd1);
    chk("idle_tag", 64'(rf_tag_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b1; flush_i = 1'b0;
    req_tag0_i = '0; req_tag1_i = '0; req_ppn0_i = '0; req_ppn1_i = '0;
    req_partial_i = 1'b0; valid_vec_i = '0;
    #12;
    chk("rst_ready", {63'd0, req_ready_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_abort", {63'd0, abort_o}, 64'd0);
    chk("rst_wr_en", {63'd0, rf_wr_en_o}, 64'd0);
    chk("rst_waddr", 64'(rf_waddr_o), 64'd0);
    req_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();

    do_refill(9'h011, 9'h022, 44'hA, 44'hB, 1'b0, 4'b0000);
    do_refill(9'h033, 9'h044, 44'hC, 44'hD, 1'b1, 4'b0011);
    for (int i = 0; i < 5; i++) do_refill(VL'(i), VL'(i + 7), PL'(i), PL'(i + 9), 1'b0, 4'b1111);

    // Flush while writing side 1.
    req_valid_i = 1'b1; valid_vec_i = '0; req_partial_i = 1'b0;
    tick(); req_valid_i = 1'b0;
    tick(); flush_i = 1'b1; #1;
    chk("fl_rf_flush", {63'd0, rf_flush_o}, 64'd1);
    chk("fl_wr_en", {63'd0, rf_wr_en_o}, 64'd0);
    chk("fl_done", {63'd0, done_o}, 64'd0);
    tick(); flush_i = 1'b0; #1;
    chk("fl_abort", {63'd0, abort_o}, 64'd1);
    chk("fl_ready", {63'd0, req_ready_o}, 64'd1);
    chk("fl_wr_en2", {63'd0, rf_wr_en_o}, 64'd0);
    m_rr = 0;
    tick(); #1;
    chk("fl_abort_end", {63'd0, abort_o}, 64'd0);
    chk("fl_no_done", {63'd0, done_o}, 64'd0);
    do_refill(9'h1FF, 9'h100, 44'h123, 44'h456, 1'b0, 4'b1111);

    // Flush with a pending request while idle.
    flush_i = 1'b1; req_valid_i = 1'b1; valid_vec_i = 4'b1111; #1;
    chk("ifl_ready", {63'd0, req_ready_o}, 64'd0);
    tick(); #1;
    chk("ifl_no_accept", {63'd0, rf_wr_en_o}, 64'd0);
    chk("ifl_abort", {63'd0, abort_o}, 64'd0);
    flush_i = 1'b0;
    m_rr = 0;
    do_refill(9'h0AA, 9'h055, 44'h777, 44'h888, 1'b0, 4'b1111);

    // Asynchronous reset in the partial-bit write cycle.
    do_refill(9'h001, 9'h002, 44'h3, 44'h4, 1'b0, 4'b1111);
    req_valid_i = 1'b1; valid_vec_i = '0; req_partial_i = 1'b0;
    tick(); req_valid_i = 1'b0;
    tick(); tick(); #1;
    chk("ar_in_wrp", {63'd0, rf_wr_part_en_o}, 64'd1);
    #2; rst_i = 1'b1; #1;
    chk("ar_part_en", {63'd0, rf_wr_part_en_o}, 64'd0);
    chk("ar_waddr", 64'(rf_waddr_o), 64'd0);
    chk("ar_ready", {63'd0, req_ready_o}, 64'd0);
    tick(); tick();
    rst_i = 1'b0;
    m_rr = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("ar_no_done", {63'd0, done_o}, 64'd0);
      chk("ar_no_abort", {63'd0, abort_o}, 64'd0);
    end
    chk("ar_ready_after", {63'd0, req_ready_o}, 64'd1);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] vv;
      vv = ($urandom_range(0, 1) == 0) ? 4'b1111 : N'($urandom);
      do_refill(VL'($urandom), VL'($urandom), {12'($urandom), 32'($urandom)},
                {12'($urandom), 32'($urandom)}, 1'($urandom), vv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tpc_refill_ctrl.md
Name: tpc_refill_ctrl

Overview:
- Sequences refills of the MMU translation-path cache register file on behalf of the page-table walker.
- Accepts one refill request per handshake and selects a victim entry: first invalid entry, else round-robin.
- Drives the regfile write ports over several cycles: side 0, then side 1, then the partial bit.
- Owns the regfile flush line and aborts any in-flight refill on flush.

Parameters:
- N_ENTRIES, MMUC_ENTRIES, number of cache entries; must be ≥2.
- VPN_PART_LEN, 9, width of one VPN part (tag).
- PPN_LEN, 44, width of a PPN.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  1  refill request valid.
- req_ready_o  out  1  controller can accept a request.
- req_tag0_i  in  VPN_PART_LEN  tag for side 0.
- req_tag1_i  in  VPN_PART_LEN  tag for side 1.
- req_ppn0_i  in  PPN_LEN  data for side 0.
- req_ppn1_i  in  PPN_LEN  data for side 1.
- req_partial_i  in  1  mebipage; only side 0 is meaningful.
- flush_i  in  1  cache flush request.
- done_o  out  1  one-cycle pulse: refill completed.
- abort_o  out  1  one-cycle pulse: refill killed by flush.
- valid_vec_i  in  N_ENTRIES  regfile valid bits.
- rf_wr_en_o  out  1  regfile write enable.
- rf_wr_part_en_o  out  1  regfile partial-bit write enable.
- rf_tag_o  out  VPN_PART_LEN  regfile tag.
- rf_data_o  out  PPN_LEN  regfile data.
- rf_partial_o  out  1  regfile partial bit.
- rf_flush_o  out  1  regfile flush.
- rf_waddr_o  out  N_ENTRIES  one-hot write address.
- rf_which_side_o  out  1  side select.

Behaviour:
- **States:** IDLE, WR0, WR1, WRP, DONE.
- **Reset:**
  - State IDLE, rr_ptr=0, all latched request fields 0.
  - Every output 0, including req_ready_o while rst_i is high.
- **req_ready_o:** = (state==IDLE) & ~flush_i; combinational.
- **Acceptance:** on req_valid_i & req_ready_o, register tag0/1, ppn0/1 and partial, and register the victim one-hot; go to WR0.
- **Victim selection:**
  - Lowest-index zero bit of valid_vec_i, sampled at acceptance.
  - If all bits are 1, use rr_ptr and set the internal flag use_rr.
- **WR0:** rf_wr_en_o=1, rf_which_side_o=0, rf_tag_o=tag0, rf_data_o=ppn0, rf_waddr_o=victim. Next state WRP if partial, else WR1.
- **WR1:** same as WR0 with side 1, tag1, ppn1. Next state WRP.
- **WRP:** rf_wr_part_en_o=1, rf_partial_o=latched partial, rf_waddr_o=victim, rf_wr_en_o=0. Next state DONE.
- **DONE:**
  - done_o=1 for one cycle.
  - If use_rr, rr_ptr <= (rr_ptr==N_ENTRIES-1) ? 0 : rr_ptr+1.
  - Next state IDLE.
- **Latency:**
  - Accept at edge 0; done_o is high in cycle 4 (cycle 3 when partial).
  - Minimum request spacing is 5 cycles (4 when partial); no acceptance in DONE.
- **Outputs outside WR0/WR1/WRP:** rf_wr_en_o, rf_wr_part_en_o, rf_waddr_o, rf_tag_o, rf_data_o, rf_partial_o and rf_which_side_o are all 0.
- **Flush:**
  - rf_flush_o = flush_i (combinational pass-through).
  - In WR0/WR1/WRP/DONE: all rf write enables forced to 0 that cycle; next state IDLE; abort_o=1 for one cycle; no done_o; rr_ptr reset to 0.
  - In IDLE: no acceptance that cycle; rr_ptr reset to 0; abort_o stays 0.
- **Ordering:** flush has priority over every other transition.
- **Mid-operation reset:** immediate return to the reset values; no done_o or abort_o is produced.
- **Index width:** rr_ptr is $clog2(N_ENTRIES) bits and wraps explicitly for non-power-of-2 N_ENTRIES.

Test Plan:
1. **Partial-free refill, empty cache:** reset; valid_vec_i=0; request tag0=0x011, tag1=0x022, ppn0=0xA, ppn1=0xB, partial=0 → cycle1 waddr=0001 side0 tag 0x011 data 0xA; cycle2 side1 tag 0x022 data 0xB; cycle3 wr_part_en, partial=0; cycle4 done_o; rr_ptr stays 0.
2. **Mebipage:** valid_vec_i=0011, partial=1 → waddr=0100; WR0 then WRP with rf_partial_o=1; WR1 never appears; done_o in cycle 3.
3. **Round-robin wrap:** N_ENTRIES=4, valid_vec_i=1111, five back-to-back requests → victims 0,1,2,3,0 (one-hot 0001,0010,0100,1000,0001).
4. **Flush in WR1:** flush_i=1 during WR1 → rf_flush_o=1 and rf_wr_en_o=0 that cycle; abort_o pulses next cycle; no done_o; rr_ptr=0; req_ready_o=1 once flush_i drops.
5. **Request with flush in IDLE:** flush_i=1 and req_valid_i=1 in IDLE → req_ready_o=0, no acceptance; acceptance occurs in the first cycle flush_i=0.
6. **Async reset while in WRP:** assert rst_i mid-cycle → all outputs 0 immediately; state IDLE; no done_o after release.
